aoc_result_tx: RTL
==================

Name: aoc_result_tx

Overview:
Transmit side of the chip's host byte interface. Takes the WIDTH-bit z result from the day-24 gate-network evaluator and sends it to the host one byte at a time, LSB byte first. Each byte uses a 4-phase valid/ack handshake on the TinyTapeout pads. It sits between the evaluator core and the uo_out/uio pad muxing in the top wrapper.

Parameters:
WIDTH, 46, result width in bits (z00..z45).
NBYTES, ceil(WIDTH/8) = 6, localparam, number of bytes transmitted.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
ena  input  1  design enable; low freezes all state
start  input  1  one-cycle request to transmit result; sampled only in IDLE
result  input  WIDTH  value to send; captured on accepted start
busy  output  1  transfer in progress
done  output  1  one-cycle pulse after last byte's handshake completes
out_data  output  8  current byte, driven to uo_out
out_valid  output  1  byte on out_data is valid, driven to a uio output bit
out_last  output  1  current byte is the final byte
host_ack  input  1  host acknowledge, raw from a uio input bit (asynchronous)

Behaviour:
- Everything is clocked on the rising edge of clk; no other clock.
- Synchronous reset (rst_n=0 at an edge) forces state=IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=8'h00, shift register=0, byte counter=0, ack sync flops=0. Reset mid-transfer aborts immediately; no partial completion; done is not pulsed.
- ena=0: all registers hold, including the ack synchronizer. Outputs keep their values. start is ignored.
- host_ack passes through a 2-flop synchronizer to ack_s. Raw-to-ack_s latency is 2 cycles. The FSM uses only ack_s.
- States: IDLE, PRESENT, WAIT_LOW, DONE.
- IDLE: busy=0, out_valid=0. When start=1, the result is captured zero-extended to NBYTES*8 bits, count=0, and the next state is PRESENT. In the following cycle busy=1, out_valid=1, out_data=result[7:0], and out_last=(NBYTES==1).
- PRESENT: out_valid=1 and out_data holds steady. When ack_s=1, the next state is WAIT_LOW and out_valid=0 in the next cycle. out_data keeps holding its value in that cycle.
- WAIT_LOW: out_valid=0. When ack_s=0:
  - if count==NBYTES-1, go to DONE;
  - otherwise shift right by 8, count+1, go to PRESENT. The next byte appears with out_valid=1 in the following cycle, and out_last=1 when the new count==NBYTES-1.
- DONE: done=1 and busy=1 for exactly one cycle, out_valid=0, out_last=0, then IDLE.
- start while busy is ignored; the captured value is not modified.
- start in the same cycle as the DONE→IDLE return is ignored. A new start is accepted only in the IDLE state.
- The top byte carries result[WIDTH-1:40] in its low bits; the upper bits are 0.
- Fastest per-byte cost with an ideal host:
  - PRESENT to WAIT_LOW takes 1 cycle after ack_s rises;
  - WAIT_LOW to the next PRESENT takes 1 cycle after ack_s falls.
- There is no timeout: the block waits for the host indefinitely.
- ack_s high while in IDLE or DONE has no effect. If ack_s is already high on entry to PRESENT (host never dropped it), the byte completes at once. This is legal; hosts must follow the 4-phase protocol.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles with random inputs → busy=0, done=0, out_valid=0, out_last=0, out_data=8'h00.
- Full transfer: result=46'h1234_56789ABC, pulse start; host model raises ack 1 cycle after out_valid and drops it 1 cycle after out_valid falls → bytes BC,9A,78,56,34,12 in order. out_last=1 only on 12. A single done pulse follows. busy drops after done.
- Padding: result=46'h3FFF_FFFF_FFFF → the final byte is 8'h3F, not 8'hFF.
- Start while busy: pulse start with result=46'h0 during byte 3 of the transfer above → the remaining bytes are still 56,34,12. There is no second transfer until the next start in IDLE.
- Stall and enable: hold host_ack low for 50 cycles with out_valid=1 → out_data stays stable. Then set ena=0 for 10 cycles while ack toggles → no state change. Restore ena → the transfer resumes correctly.
- Reset mid-transfer: assert rst_n=0 after byte 2 is acked → IDLE with all outputs at reset values and no done pulse. A new start sends from byte 0.

Source files
------------

// File: rtl/aoc_result_tx.sv
`default_nettype none
// ============================================================================
// Module : aoc_result_tx
// Sends the evaluator result to the host LSB byte first, 4-phase valid/ack.
// Rev    : 1.0  initial release
// ============================================================================
module aoc_result_tx #(
  parameter int WIDTH = 46
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             host_ack
);

  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] c_last = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESENT  = 2'd1,
    S_WAIT_LOW = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NBYTES*8-1:0]   r_shift;
  logic [NBYTES*8-1:0]   w_shift_nxt;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_ack_meta;
  logic                  r_ack_s;

  // host_ack is asynchronous to clk; only r_ack_s reaches the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_count    <= '0;
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else if (ena) begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_count    <= w_count_nxt;
      r_ack_meta <= host_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt              = S_PRESENT;
          w_shift_nxt              = '0;
          w_shift_nxt[WIDTH-1:0]   = result;
          w_count_nxt              = '0;
        end
      end
      S_PRESENT: begin
        if (r_ack_s) begin
          w_state_nxt = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!r_ack_s) begin
          if (r_count == c_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_PRESENT;
            w_shift_nxt = r_shift >> 8;
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // out_data keeps the last byte after the transfer; reset clears it to 0
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    out_valid = (r_state == S_PRESENT);
    out_data  = r_shift[7:0];
    out_last  = ((r_state == S_PRESENT) || (r_state == S_WAIT_LOW)) && (r_count == c_last);
  end

endmodule
`default_nettype wire
